dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 3, giving the memory access cycles per transaction; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the system clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have pipeline port inputs p_req 1, p_we 1, p_addr 32, p_wdata 32; outputs p_done 1, p_rdata 32, p_stall 1.
REQ-005 SHALL have debug port inputs d_req 1, d_we 1, d_addr 32, d_wdata 32; outputs d_done 1, d_rdata 32.
REQ-006 SHALL have memory-side outputs m_re 1, m_we 1, m_addr 6 (byte address bits [7:2]), m_wd 32, and memory-side input m_rd 32.
REQ-007 SHALL have status outputs err 1 (rejected-access pulse), owner 1 (0 = pipeline, 1 = debug) and busy 1.
REQ-008 SHALL have counter outputs perf_p 16, perf_d 16, perf_conflict 16 and perf_err 16.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, DONE and ERR; busy = (state != IDLE).
REQ-010 In IDLE with exactly one request, SHALL grant that requester and latch its we, addr and wdata.
REQ-011 In IDLE with both requests, SHALL grant the requester not granted last (round-robin); last_grant resets to debug, so the pipeline wins the first conflict.
REQ-012 SHALL set owner to the granted requester, held from grant until return to IDLE.
REQ-013 A latched access SHALL be rejected, going IDLE->ERR, if addr[1:0] != 0, addr >= 32'h1000_0000, or we=1 with 32'h1000 <= addr < 32'h2000.
REQ-014 ERR SHALL last one cycle and assert err plus the owner's done, with no m_re/m_we; the next state is IDLE.
REQ-015 A valid access SHALL go IDLE->ACCESS and stay in ACCESS for exactly LATENCY cycles, counted by a 4-bit down-counter.
REQ-016 m_re or m_we (per latched we) SHALL assert only on the first ACCESS cycle; m_addr and m_wd SHALL be driven from latched values throughout ACCESS.
REQ-017 On a read, SHALL capture m_rd on the last ACCESS cycle into the owner's rdata register, which holds until that owner's next read completes.
REQ-018 DONE SHALL last one cycle, pulse the owner's done, and go to IDLE.
REQ-019 Latency SHALL be: request sampled in IDLE at edge N, done high in cycle N+LATENCY+1.
REQ-020 Handshake: a requester SHALL keep req and its payload stable until done; req still high in the IDLE after DONE is treated as a new request.
REQ-021 p_stall SHALL equal p_req & ~p_done (combinational).
REQ-022 p_done and d_done SHALL never assert in the same cycle; err SHALL never assert outside ERR.
REQ-023 Write then read of the same address by different owners SHALL return the written data (serialised; no reordering).

Reset
REQ-024 On reset, state = IDLE, counter = 0, last_grant = debug, owner = 0, and p_rdata, d_rdata and all perf counters = 0.
REQ-025 On reset, done, err, busy, m_re and m_we SHALL be 0 immediately, including reset asserted mid-ACCESS; the interrupted transaction is dropped with no done.

Configuration
REQ-026 Macro DMEM_ARB_PERF_EN defined: perf_p/perf_d SHALL count completed valid transactions per owner, perf_conflict SHALL count IDLE cycles with both requests, and perf_err SHALL count ERR entries; all saturate at 16'hFFFF.
REQ-027 Macro DMEM_ARB_PERF_EN undefined: all perf outputs SHALL be constant 0 and no counter logic is generated; ports are identical in both builds.

Verification
REQ-028 Pipeline read addr 32'h40, LATENCY=3, m_rd=32'hDEADBEEF -> m_re one cycle with m_addr=6'h10; p_done 4 cycles after sampling; p_rdata=32'hDEADBEEF.
REQ-029 p_req and d_req both high from reset -> pipeline served first, then debug; perf_conflict=1 with PERF_EN.
REQ-030 Debug write addr 32'h1004 -> ERR: err=1, d_done=1 one cycle after grant, m_we never high, perf_err=1.
REQ-031 Pipeline read addr 32'h42 -> err=1 and p_done=1 at cycle N+1; p_rdata unchanged.
REQ-032 Reset asserted on the second ACCESS cycle -> m_re/m_we/done/busy 0 immediately; after release a new p_req completes normally.
REQ-033 Both requesters held high for 6 transactions -> strict alternation P,D,P,D,P,D; perf_p=3, perf_d=3.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the pipeline and the debug port.
// Define DMEM_ARB_PERF_EN to build the saturating performance counters; otherwise they read 0.
module dmem_arbiter #(
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  output logic        p_done,
  output logic [31:0] p_rdata,
  output logic        p_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        m_re,
  output logic        m_we,
  output logic [5:0]  m_addr,
  output logic [31:0] m_wd,
  input  logic [31:0] m_rd,
  output logic        err,
  output logic        owner,
  output logic        busy,
  output logic [15:0] perf_p,
  output logic [15:0] perf_d,
  output logic [15:0] perf_conflict,
  output logic [15:0] perf_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_e;

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [5:0]  maddr_q, maddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] p_rdata_q, p_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        gnt_dbg;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_bad;

  // last_q = 1 means debug was granted last, so the pipeline wins the next conflict
  assign gnt_dbg   = d_req & (~p_req | ~last_q);
  assign sel_we    = gnt_dbg ? d_we    : p_we;
  assign sel_addr  = gnt_dbg ? d_addr  : p_addr;
  assign sel_wdata = gnt_dbg ? d_wdata : p_wdata;
  assign sel_bad   = (sel_addr[1:0] != 2'b00) ||
                     (sel_addr >= 32'h1000_0000) ||
                     (sel_we && (sel_addr >= 32'h0000_1000) && (sel_addr < 32'h0000_2000));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      maddr_q   <= 6'd0;
      wdata_q   <= 32'd0;
      p_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      maddr_q   <= maddr_d;
      wdata_q   <= wdata_d;
      p_rdata_q <= p_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    owner_d   = owner_q;
    we_d      = we_q;
    maddr_d   = maddr_q;
    wdata_d   = wdata_q;
    p_rdata_d = p_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (p_req || d_req) begin
          owner_d = gnt_dbg;
          last_d  = gnt_dbg;
          we_d    = sel_we;
          maddr_d = sel_addr[7:2];
          wdata_d = sel_wdata;
          if (sel_bad) begin
            state_d = ERR;
          end else begin
            state_d = ACCESS;
            cnt_d   = LAT4;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          if (!we_q) begin
            if (owner_q) d_rdata_d = m_rd;
            else         p_rdata_d = m_rd;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_re   = 1'b0;
    m_we   = 1'b0;
    p_done = 1'b0;
    d_done = 1'b0;
    err    = 1'b0;
    case (state_q)
      ACCESS: begin
        if (cnt_q == LAT4) begin
          m_re = ~we_q;
          m_we = we_q;
        end
      end
      DONE: begin
        p_done = ~owner_q;
        d_done = owner_q;
      end
      ERR: begin
        err    = 1'b1;
        p_done = ~owner_q;
        d_done = owner_q;
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign owner   = owner_q;
  assign m_addr  = maddr_q;
  assign m_wd    = wdata_q;
  assign p_rdata = p_rdata_q;
  assign d_rdata = d_rdata_q;
  assign p_stall = p_req & ~p_done;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] perf_p_q, perf_d_q, perf_conf_q, perf_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_p_q    <= 16'd0;
      perf_d_q    <= 16'd0;
      perf_conf_q <= 16'd0;
      perf_err_q  <= 16'd0;
    end else begin
      if (state_q == DONE && !owner_q && perf_p_q != 16'hFFFF) perf_p_q <= perf_p_q + 16'd1;
      if (state_q == DONE &&  owner_q && perf_d_q != 16'hFFFF) perf_d_q <= perf_d_q + 16'd1;
      if (state_q == IDLE && p_req && d_req && perf_conf_q != 16'hFFFF)
        perf_conf_q <= perf_conf_q + 16'd1;
      if (state_q == ERR && perf_err_q != 16'hFFFF) perf_err_q <= perf_err_q + 16'd1;
    end
  end

  assign perf_p        = perf_p_q;
  assign perf_d        = perf_d_q;
  assign perf_conflict = perf_conf_q;
  assign perf_err      = perf_err_q;
`else
  assign perf_p        = 16'd0;
  assign perf_d        = 16'd0;
  assign perf_conflict = 16'd0;
  assign perf_err      = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts grant order, results
// and done timing; a negedge monitor compares every done pulse against the predicted queue.
module tb_dmem_arbiter;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p_req = 1'b0, p_we = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0, d_addr = '0, d_wdata = '0;
  logic        p_done, p_stall, d_done, m_re, m_we, err, owner, busy;
  logic [31:0] p_rdata, d_rdata, m_wd, m_rd;
  logic [5:0]  m_addr;
  logic [15:0] perf_p, perf_d, perf_conflict, perf_err;

  dmem_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_done(p_done), .p_rdata(p_rdata), .p_stall(p_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wd(m_wd), .m_rd(m_rd),
    .err(err), .owner(owner), .busy(busy),
    .perf_p(perf_p), .perf_d(perf_d), .perf_conflict(perf_conflict), .perf_err(perf_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct { bit who; bit we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
  typedef struct { bit who; bit err; bit we; logic [5:0] maddr; logic [31:0] rdata; int cycle; } exp_t;

  txn_t pq[$];
  txn_t dq[$];
  exp_t sb[$];

  function automatic logic [31:0] init_word(int i);
    if (i == 16) return 32'hDEADBEEF;
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // memory device on the arbiter's memory port
  logic [31:0] mem_dev [64];
  assign m_rd = mem_dev[m_addr];
  initial begin
    for (int i = 0; i < 64; i++) mem_dev[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (m_we) mem_dev[m_addr] <= m_wd;
    end
  end

  // reference model state
  logic [31:0] mdl_mem [64];
  bit          mdl_last;
  logic [31:0] mdl_rd_p, mdl_rd_d;
  int          mdl_pp, mdl_pd, mdl_conf, mdl_err;

  task automatic model_reset();
    mdl_last = 1'b1;
    mdl_rd_p = '0; mdl_rd_d = '0;
    mdl_pp = 0; mdl_pd = 0; mdl_conf = 0; mdl_err = 0;
  endtask

  function automatic bit rejected(txn_t t);
    return (t.addr[1:0] != 2'b00) || (t.addr >= 32'h1000_0000) ||
           (t.we && t.addr >= 32'h1000 && t.addr < 32'h2000);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Serve the pending lists one at a time from idle cycle k: alternate when both wait.
  task automatic plan(int k);
    txn_t a[$] = pq;
    txn_t b[$] = dq;
    int idle = k;
    while (a.size() > 0 || b.size() > 0) begin
      bit who;
      txn_t t;
      exp_t e;
      if (a.size() > 0 && b.size() > 0) begin
        who = ~mdl_last;
        mdl_conf++;
      end else begin
        who = (a.size() == 0);
      end
      t = who ? b.pop_front() : a.pop_front();
      mdl_last = who;
      e.who = who; e.we = t.we; e.maddr = t.addr[7:2];
      e.err = rejected(t);
      if (e.err) begin
        mdl_err++;
        e.cycle = idle + 1;
      end else begin
        if (t.we) mdl_mem[t.addr[7:2]] = t.wdata;
        else if (who) mdl_rd_d = mdl_mem[t.addr[7:2]];
        else mdl_rd_p = mdl_mem[t.addr[7:2]];
        if (who) mdl_pd++; else mdl_pp++;
        e.cycle = idle + LAT + 1;
      end
      e.rdata = who ? mdl_rd_d : mdl_rd_p;
      sb.push_back(e);
      idle = e.cycle + 1;
    end
  endtask

  task automatic drive_p(txn_t t);
    p_req = 1'b1; p_we = t.we; p_addr = t.addr; p_wdata = t.wdata;
  endtask

  task automatic drive_d(txn_t t);
    d_req = 1'b1; d_we = t.we; d_addr = t.addr; d_wdata = t.wdata;
  endtask

  task automatic run_batch();
    int budget = 300;
    @(negedge clk);
    plan(cyc);
    if (pq.size() > 0) drive_p(pq[0]);
    if (dq.size() > 0) drive_d(dq[0]);
    while ((pq.size() > 0 || dq.size() > 0) && budget > 0) begin
      @(negedge clk);
      budget--;
      if (p_done && pq.size() > 0) begin
        void'(pq.pop_front());
        if (pq.size() > 0) drive_p(pq[0]); else p_req = 1'b0;
      end
      if (d_done && dq.size() > 0) begin
        void'(dq.pop_front());
        if (dq.size() > 0) drive_d(dq[0]); else d_req = 1'b0;
      end
    end
    if (pq.size() > 0 || dq.size() > 0) begin
      total++; bad++;
      $display("FAIL batch_timeout: got %0d pending expected 0", pq.size() + dq.size());
      pq.delete(); dq.delete(); sb.delete();
      p_req = 1'b0; d_req = 1'b0;
    end
  endtask

  function automatic txn_t mk(bit who, bit we, logic [31:0] addr, logic [31:0] wdata);
    txn_t t;
    t.who = who; t.we = we; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t rand_txn(bit who);
    logic [31:0] r = $urandom;
    int kind = $urandom_range(0, 9);
    logic [31:0] a;
    if (kind <= 5)      a = {24'h0, r[7:2], 2'b00};
    else if (kind == 6) a = r & 32'h0FFF_FFFC;
    else if (kind == 7) a = 32'h1000 | (r & 32'h0000_0FFC);
    else if (kind == 8) a = (r & 32'h0000_00FE) | 32'h1;
    else                a = 32'h1000_0000 | r;
    return mk(who, 1'($urandom_range(0, 1)), a, $urandom);
  endfunction

  task automatic check_perf(string tag);
`ifdef DMEM_ARB_PERF_EN
    chk({tag, "_perf_p"}, {16'h0, perf_p}, 32'(mdl_pp));
    chk({tag, "_perf_d"}, {16'h0, perf_d}, 32'(mdl_pd));
    chk({tag, "_perf_conflict"}, {16'h0, perf_conflict}, 32'(mdl_conf));
    chk({tag, "_perf_err"}, {16'h0, perf_err}, 32'(mdl_err));
`else
    chk({tag, "_perf_p"}, {16'h0, perf_p}, 32'h0);
    chk({tag, "_perf_d"}, {16'h0, perf_d}, 32'h0);
    chk({tag, "_perf_conflict"}, {16'h0, perf_conflict}, 32'h0);
    chk({tag, "_perf_err"}, {16'h0, perf_err}, 32'h0);
`endif
  endtask

  // monitor: compares every done pulse with the head of the scoreboard
  int          pulses = 0;
  logic [5:0]  pulse_addr = '0;
  bit          pulse_we = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        pulses = 0;
      end else begin
        chk("done_exclusive", {31'h0, p_done & d_done}, 32'h0);
        if (m_re || m_we) begin
          pulses++; pulse_addr = m_addr; pulse_we = m_we;
        end
        if (err && !(p_done || d_done)) chk("err_without_done", {31'h0, err}, 32'h0);
        if (p_done || d_done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", {30'h0, d_done, p_done}, 32'h0);
          end else begin
            e = sb.pop_front();
            chk("done_who", {31'h0, d_done}, {31'h0, e.who});
            chk("owner", {31'h0, owner}, {31'h0, e.who});
            chk("err_flag", {31'h0, err}, {31'h0, e.err});
            chk("done_cycle", 32'(cyc), 32'(e.cycle));
            chk("rdata", e.who ? d_rdata : p_rdata, e.rdata);
            chk("mem_strobes", 32'(pulses), e.err ? 32'd0 : 32'd1);
            if (!e.err) begin
              chk("m_addr", {26'h0, pulse_addr}, {26'h0, e.maddr});
              chk("strobe_is_we", {31'h0, pulse_we}, {31'h0, e.we});
            end
          end
          pulses = 0;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) mdl_mem[i] = init_word(i);
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_owner", {31'h0, owner}, 32'h0);
    chk("rst_strobes", {30'h0, m_re, m_we}, 32'h0);
    chk("rst_done_err", {29'h0, p_done, d_done, err}, 32'h0);
    chk("rst_p_rdata", p_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    check_perf("rst");
    @(negedge clk);
    reset = 1'b0;

    // both requesters from reset: pipeline first, then debug
    pq.push_back(mk(1'b0, 1'b0, 32'h40, 32'h0));
    dq.push_back(mk(1'b1, 1'b0, 32'h44, 32'h0));
    run_batch();
    check_perf("conflict1");

    // six back-to-back transactions with both held high: strict alternation
    for (int i = 0; i < 3; i++) begin
      pq.push_back(mk(1'b0, 1'b1, 32'h80 + 32'(i * 4), 32'hA000_0000 + 32'(i)));
      dq.push_back(mk(1'b1, 1'b0, 32'h80 + 32'(i * 4), 32'h0));
    end
    run_batch();
    check_perf("alternate");

    // debug write to the write-protected window, then misaligned pipeline read
    dq.push_back(mk(1'b1, 1'b1, 32'h1004, 32'h1234_5678));
    run_batch();
    pq.push_back(mk(1'b0, 1'b0, 32'h42, 32'h0));
    run_batch();
    check_perf("errors");

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      int mode = $urandom_range(0, 2);
      int np = (mode == 1) ? 0 : $urandom_range(1, 3);
      int nd = (mode == 0) ? 0 : $urandom_range(1, 3);
      for (int i = 0; i < np; i++) pq.push_back(rand_txn(1'b0));
      for (int i = 0; i < nd; i++) dq.push_back(rand_txn(1'b1));
      run_batch();
    end
    check_perf("random");

    // reset in the second ACCESS cycle drops the transaction
    @(negedge clk);
    drive_p(mk(1'b0, 1'b0, 32'h40, 32'h0));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    p_req = 1'b0;
    #1;
    chk("midrst_strobes", {30'h0, m_re, m_we}, 32'h0);
    chk("midrst_done", {30'h0, p_done, d_done}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("midrst_p_rdata", p_rdata, 32'h0);
    check_perf("midrst");
    pq.push_back(mk(1'b0, 1'b0, 32'h40, 32'h0));
    run_batch();
    check_perf("final");

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
